// File: rtl/fib_index_decoder.sv
// -----------------------------------------------------------------------------
// fib_index_decoder
//
// Value-to-index companion of the Fibonacci sequence generator. Given a target
// value and the same 2-bit seeds the generator uses, it steps the sequence one
// term per clock. It reports whether the target is a term and, if it is, the
// lowest index at which the target appears.
//
// Sequence: T(-1) = f1, T0 = f0, Tk = T(k-1) + T(k-2), with both seeds
// zero-extended to DATA_W bits.
//
// Parameters
//   DATA_W  width of the target and of the sequence terms (default 16)
//   IDX_W   width of the index counter; the search stops at 2**IDX_W - 1
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset (takes priority over start)
//   start    search request; sampled only while idle
//   target   value to locate; captured when start is accepted
//   f0, f1   2-bit seeds; captured when start is accepted
//   busy     high while a search is in progress
//   done     one-cycle pulse when found/index (and nearest) are valid
//   found    target is a sequence term; held until the next termination
//   index    lowest matching index when found, else 0; held
//   nearest  (FIB_NEAREST_EN only) closest term not above the target for a
//            miss, the target itself for a hit; held, updated with done
//
// Optional feature macro: FIB_NEAREST_EN (adds the nearest output port).
// -----------------------------------------------------------------------------
module fib_index_decoder #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] target,
    input  logic [1:0]        f0,
    input  logic [1:0]        f1,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [IDX_W-1:0]  index
`ifdef FIB_NEAREST_EN
    ,
    output logic [DATA_W-1:0] nearest
`endif
);

    localparam logic [IDX_W-1:0] MAX_INDEX = {IDX_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   a_r;        // current term Tk
    logic [DATA_W-1:0]   b_r;        // previous term T(k-1)
    logic [IDX_W-1:0]    k_r;        // index of a_r
    logic [DATA_W-1:0]   tgt_r;      // latched target

    logic [DATA_W:0]     sum_s;      // next term with carry in the top bit
    logic                hit_s;
    logic                over_s;
    logic                carry_s;
    logic                limit_s;
    logic                term_s;     // search ends on the current term
    logic                found_nxt_s;
    logic [IDX_W-1:0]    index_nxt_s;
    logic [DATA_W-1:0]   near_nxt_s;

    // Next-term adder and the termination tests, in their priority order.
    always_comb begin
        sum_s       = {1'b0, a_r} + {1'b0, b_r};
        hit_s       = 1'b0;
        over_s      = 1'b0;
        carry_s     = 1'b0;
        limit_s     = 1'b0;
        found_nxt_s = 1'b0;
        index_nxt_s = {IDX_W{1'b0}};
        near_nxt_s  = {DATA_W{1'b0}};
        if (a_r == tgt_r) begin
            hit_s       = 1'b1;
            found_nxt_s = 1'b1;
            index_nxt_s = k_r;
            near_nxt_s  = tgt_r;
        end else if (a_r > tgt_r) begin
            // Terms only grow from T0, so the previous term is the largest
            // one below the target; at k = 0 there is no earlier term.
            over_s = 1'b1;
            if (k_r != {IDX_W{1'b0}}) begin
                near_nxt_s = b_r;
            end else begin
                near_nxt_s = {DATA_W{1'b0}};
            end
        end else if (sum_s[DATA_W] == 1'b1) begin
            carry_s    = 1'b1;
            near_nxt_s = a_r;
        end else if (k_r == MAX_INDEX) begin
            // Stops non-growing seeds such as f0 = f1 = 0.
            limit_s    = 1'b1;
            near_nxt_s = a_r;
        end else begin
            near_nxt_s = {DATA_W{1'b0}};
        end
        term_s = hit_s | over_s | carry_s | limit_s;
    end

    // Search FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= {DATA_W{1'b0}};
            b_r     <= {DATA_W{1'b0}};
            k_r     <= {IDX_W{1'b0}};
            tgt_r   <= {DATA_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            found   <= 1'b0;
            index   <= {IDX_W{1'b0}};
`ifdef FIB_NEAREST_EN
            nearest <= {DATA_W{1'b0}};
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        tgt_r   <= target;
                        a_r     <= {{(DATA_W-2){1'b0}}, f0};
                        b_r     <= {{(DATA_W-2){1'b0}}, f1};
                        k_r     <= {IDX_W{1'b0}};
                        busy    <= 1'b1;
                        state_r <= ST_SEARCH;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SEARCH: begin
                    // start is not looked at here, so requests made while
                    // busy are simply dropped.
                    if (term_s) begin
                        found   <= found_nxt_s;
                        index   <= index_nxt_s;
`ifdef FIB_NEAREST_EN
                        nearest <= near_nxt_s;
`endif
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        a_r     <= sum_s[DATA_W-1:0];
                        b_r     <= a_r;
                        k_r     <= k_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        busy    <= 1'b1;
                        state_r <= ST_SEARCH;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef FIB_NEAREST_EN
    // Nearest-term result is only consumed when the feature is built in.
    logic unused_near_s;
    assign unused_near_s = ^near_nxt_s;
`endif

endmodule

// File: tb/tb_fib_index_decoder.sv
// -----------------------------------------------------------------------------
// tb_fib_index_decoder
//
// Self-checking bench for fib_index_decoder. A reference model builds the
// whole sequence with plain integer arithmetic and reads the expected result
// off that list. Directed cases, randomized seeds/targets, back-to-back
// starts and a mid-search reset are checked. Define FIB_NEAREST_EN to also
// check the nearest output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fib_index_decoder;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 5;
    localparam int MAXK   = 31;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] target;
    logic [1:0]        f0;
    logic [1:0]        f1;
    logic              busy;
    logic              done;
    logic              found;
    logic [IDX_W-1:0]  index;
`ifdef FIB_NEAREST_EN
    logic [DATA_W-1:0] nearest;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_index_decoder #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .target (target),
        .f0     (f0),
        .f1     (f1),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .index  (index)
`ifdef FIB_NEAREST_EN
        ,
        .nearest(nearest)
`endif
    );

    // Reference: list T(-1)..T(32) exactly, then scan for the first term that
    // equals or passes the target, whose successor overflows, or hits the cap.
    task automatic model(input int s0, input int s1, input int tg,
                         output bit m_found, output int m_idx,
                         output int m_lat, output int m_near);
        longint t[0:33];           // t[j] holds T(j-1)
        t[0] = s1;
        t[1] = s0;
        for (int j = 2; j <= 33; j++) t[j] = t[j-1] + t[j-2];
        m_found = 1'b0; m_idx = 0; m_lat = 0; m_near = 0;
        for (int k = 0; k <= MAXK; k++) begin
            if (t[k+1] == tg) begin
                m_found = 1'b1; m_idx = k; m_lat = k + 1; m_near = tg;
                return;
            end
            if (t[k+1] > tg) begin
                m_lat = k + 1; m_near = (k > 0) ? int'(t[k]) : 0;
                return;
            end
            if (t[k+1] + t[k] > 65535 || k == MAXK) begin
                m_lat = k + 1; m_near = int'(t[k+1]);
                return;
            end
        end
    endtask

    // Returns the list term T(k) for picking reachable targets.
    function automatic longint term_of(input int s0, input int s1, input int k);
        longint p = s1;
        longint c = s0;
        longint n;
        for (int j = 0; j < k; j++) begin
            n = c + p; p = c; c = n;
        end
        return c;
    endfunction

    // Issues one search (caller is already past an edge) and compares the
    // outcome; returns in the done cycle, #1 after the edge.
    task automatic run_search(input string name, input int s0, input int s1,
                              input int tg);
        bit m_found; int m_idx, m_lat, m_near;
        int cyc, nbusy;
        model(s0, s1, tg, m_found, m_idx, m_lat, m_near);
        f0 = 2'(s0); f1 = 2'(s1); target = DATA_W'(tg); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nbusy = busy ? 1 : 0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) nbusy++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d edges, expected %0d", name, cyc, m_lat);
            return;
        end
        checks++;
        if (cyc !== m_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, m_lat);
        end
        checks++;
        if (nbusy !== m_lat || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: high %0d cycles (now %b) expected %0d (now 0)", name, nbusy, busy, m_lat);
        end
        checks++;
        if (found !== m_found || int'(index) !== m_idx) begin
            errors++;
            $display("FAIL %s result: found=%b index=%0d expected found=%b index=%0d",
                     name, found, index, m_found, m_idx);
        end
`ifdef FIB_NEAREST_EN
        checks++;
        if (int'(nearest) !== m_near) begin
            errors++;
            $display("FAIL %s nearest: got %0d expected %0d", name, nearest, m_near);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; target = '0; f0 = 2'd0; f1 = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || index !== 5'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b found=%b index=%0d expected all 0", busy, done, found, index);
        end
`ifdef FIB_NEAREST_EN
        checks++;
        if (nearest !== 16'd0) begin
            errors++;
            $display("FAIL reset_nearest: got %0d expected 0", nearest);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_search("fib21", 0, 1, 21);
        // done must be a single-cycle pulse, results held afterwards
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || found !== 1'b1 || index !== 5'd8) begin
            errors++;
            $display("FAIL hold: done=%b found=%b index=%0d expected done=0 found=1 index=8", done, found, index);
        end
        run_search("fib1_lowest", 0, 1, 1);
        run_search("fib4_miss", 0, 1, 4);
        run_search("seed32_13", 3, 2, 13);
        run_search("carry50000", 0, 1, 50000);
        run_search("target0", 0, 1, 0);
        run_search("seed0_above", 3, 3, 2);
        run_search("max_target", 3, 1, 65535);
    endtask

    task automatic test_random();
        int s0, s1, tg, mode;
        for (int n = 0; n < 40; n++) begin
            s0 = int'($urandom_range(0, 3));
            s1 = int'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                tg = int'($urandom_range(0, 65535));
            end else if (mode == 1) begin
                tg = int'($urandom_range(0, 40));
            end else begin
                tg = int'(term_of(s0, s1, int'($urandom_range(0, 22))));
                if (tg > 65535) tg = 65535;
                if (mode == 3 && tg < 65535) tg = tg + 1;
            end
            run_search($sformatf("rand%0d", n), s0, s1, tg);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        run_search("limit00", 0, 0, 5);
        // still in the done cycle: this start must be accepted
        run_search("b2b_target0", 0, 0, 0);
        run_search("b2b_again", 2, 1, 7);
    endtask

    task automatic test_rst_mid();
        int seen_done = 0;
        int seen_busy = 0;
        f0 = 2'd0; f1 = 2'd1; target = 16'd21; start = 1'b1;
        @(posedge clk); #1;                    // E0
        start = 1'b0;
        @(posedge clk); #1;                    // k=1
        start = 1'b1; target = 16'd1;          // ignored while busy
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;                    // k=4
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_start: busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || index !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b done=%b found=%b index=%0d expected all 0", busy, done, found, index);
        end
        rst = 1'b0; start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        checks++;
        if (seen_done != 0 || seen_busy != 0) begin
            errors++;
            $display("FAIL rst_no_resume: done pulses=%0d busy cycles=%0d expected 0 and 0", seen_done, seen_busy);
        end
        run_search("after_rst", 0, 1, 21);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
